square_mod: RTL
===============

# square_mod

Sequential modular squarer for the trial-factoring datapath: computes y = (x·x·(dbl ? 2 : 1)) mod m over BITWIDTH-bit operands, one interleaved shift-add-reduce step per cycle. It succeeds the single-cycle full-width squarer by doing three things that block does not:

- reduces modulo a runtime modulus m, so a 2·BITWIDTH-bit product never exists;
- provides a fused "square then double" mode, which gives one left-to-right step of 2^p mod q per operation;
- uses valid/ready handshakes on both sides.

It sits between the exponent-bit sequencer, which drives dbl from the current bit of p, and the candidate-factor comparator.

## Interface

Parameters:
- BITWIDTH, default 32, is the operand, modulus and result width. Legal values are ≥ 2.

Ports:
- sys_clk  in  1  Clock. All state updates on the rising edge.
- sys_rst  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Request valid.
- in_ready  out  1  Request accepted when in_valid & in_ready at a rising edge.
- x  in  BITWIDTH  Operand. Must satisfy x < m.
- m  in  BITWIDTH  Modulus. Must satisfy m ≥ 1.
- dbl  in  1  1 = also multiply the square by 2 (mod m).
- out_valid  out  1  Result valid. Held until out_ready.
- out_ready  in  1  Downstream accepts when out_valid & out_ready at a rising edge.
- y  out  BITWIDTH  Result, always < m when err = 0.
- err  out  1  Qualified by out_valid. 1 = illegal request (x ≥ m or m = 0).

## Operation

- States are IDLE, RUN, DBL and DONE. The reset state is IDLE.
- Registers are xr and mr (BITWIDTH bits each), dr (1 bit), an accumulator acc (BITWIDTH+1 bits internally), and a bit counter cnt (clog2(BITWIDTH) bits).
- in_ready = (state == IDLE) & ~sys_rst.
- out_valid = (state == DONE).
- y and err are registers that change only on entry to DONE.

State transitions:
- **IDLE, on accept:**
  - If x ≥ m or m == 0: go to DONE with err = 1 and y = 0.
  - Otherwise: latch xr = x, mr = m, dr = dbl; set acc = 0 and cnt = BITWIDTH-1; go to RUN.
- **RUN, each cycle, with the bit index taken from cnt, MSB first:**
  - t = 2·acc; if t ≥ mr, t = t − mr.
  - If xr[cnt] = 1: t = t + xr; if t ≥ mr, t = t − mr.
  - acc = t.
  - When cnt == 0: go to DBL if dr, else DONE. Otherwise decrement cnt.
- **DBL, one cycle:**
  - t = 2·acc; if t ≥ mr, t = t − mr. Set acc = t, then go to DONE.
- **Entry to DONE (non-error):** y = acc[BITWIDTH-1:0], err = 0.
- **DONE:**
  - Hold y, err and out_valid stable while out_ready = 0.
  - On out_ready, go to IDLE.

Arithmetic and width rules:
- All intermediates are at most BITWIDTH+1 bits wide. Invariants acc < mr and t < 2·mr guarantee that a single conditional subtract suffices.
- No multiplier and no 2·BITWIDTH-bit datapath is permitted.

Boundary conditions:
- m = 1 with x = 0: a legal request, returns y = 0.
- x = m−1: (−1)² gives y = 1, or y = 2 mod m with dbl.
- in_valid while not IDLE: ignored, since in_ready = 0. The inputs x, m and dbl may change freely after acceptance.
- Reset asserted mid-operation: state goes to IDLE immediately. out_valid, y and err go to 0 and in_ready goes to 0 until release. The in-flight operation is discarded.

## Timing

- Reset values:
  - out_valid = 0, y = 0, err = 0, in_ready = 0 while sys_rst is high.
  - in_ready = 1 from the first cycle after release.
  - Internal acc, cnt, xr, mr and dr are all 0.
- Latency, counted from the accepting edge to the edge after which out_valid is high:
  - BITWIDTH cycles when dbl = 0.
  - BITWIDTH+1 cycles when dbl = 1.
  - 1 cycle for an error request.
- The out_valid & out_ready edge returns the block to IDLE. in_ready is high in the following cycle.
- Peak throughput is one operation per BITWIDTH+2 cycles with dbl = 0 and no back-pressure.
- There is no combinational path from in_valid or out_ready to in_ready or out_valid.

## Test plan

1. BITWIDTH=32, x=5, m=7, dbl=0 → y=4, err=0, out_valid exactly 32 cycles after accept. Repeat with dbl=1 → y=1 at 33 cycles.
2. x=0xFFFFFFFE, m=0xFFFFFFFF: dbl=0 → y=1; dbl=1 → y=2. Also m=1, x=0 → y=0, err=0.
3. Illegal requests, each with out_valid 1 cycle after accept:
   - x=7, m=7 → err=1, y=0.
   - x=0, m=0 → err=1, y=0.
4. Back-pressure: hold out_ready=0 for 10 cycles after out_valid → y, err and out_valid stay stable. Drive in_valid with new operands throughout → in_ready=0 and the request is not taken. It is accepted only after the out_ready handshake.
5. Reset mid-RUN: assert sys_rst at cycle 10 of an operation → out_valid=0, y=0, in_ready=0 during reset. After release, x=3, m=11, dbl=1 → y=7 (18 mod 11).
6. Randomised check at BITWIDTH=8: run exhaustively over all m in 1..255 and all x < m, both dbl values. Compare against the model (x·x·(dbl+1)) mod m, with random out_ready stalls and back-to-back requests.

Source files
------------

// File: rtl/square_mod.sv
// Sequential modular squarer: y = x*x*(dbl ? 2 : 1) mod m, one interleaved
// shift-add-reduce step per cycle, valid/ready handshakes on both sides.
module square_mod #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] x,
  input  logic [BITWIDTH-1:0] m,
  input  logic                dbl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] y,
  output logic                err
);

  localparam int unsigned CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DBL,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [BITWIDTH-1:0] r_xr;
  logic [BITWIDTH-1:0] r_mr;
  logic                r_dr;
  logic [BITWIDTH:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic [BITWIDTH-1:0] r_y;
  logic                r_err;

  logic [BITWIDTH:0]   w_mr_ext;
  logic [BITWIDTH:0]   w_dbl_raw;
  logic [BITWIDTH:0]   w_dbl_red;
  logic [BITWIDTH:0]   w_add_raw;
  logic [BITWIDTH:0]   w_add_red;
  logic [BITWIDTH:0]   w_step;
  logic                w_bit;
  logic                w_illegal;

  // acc < mr always holds, so 2*acc and (reduced)+xr both stay below 2*mr
  // and fit in BITWIDTH+1 bits; one conditional subtract restores acc < mr.
  assign w_mr_ext  = {1'b0, r_mr};
  assign w_dbl_raw = r_acc << 1;
  assign w_dbl_red = (w_dbl_raw >= w_mr_ext) ? (w_dbl_raw - w_mr_ext) : w_dbl_raw;
  assign w_add_raw = w_dbl_red + {1'b0, r_xr};
  assign w_add_red = (w_add_raw >= w_mr_ext) ? (w_add_raw - w_mr_ext) : w_add_raw;
  assign w_bit     = r_xr[r_cnt];
  assign w_step    = w_bit ? w_add_red : w_dbl_red;

  assign w_illegal = (x >= m) || (m == '0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_xr    <= '0;
      r_mr    <= '0;
      r_dr    <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_illegal) begin
              r_y     <= '0;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_xr    <= x;
              r_mr    <= m;
              r_dr    <= dbl;
              r_acc   <= '0;
              r_cnt   <= CW'(BITWIDTH - 1);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          if (r_cnt == '0) begin
            if (r_dr) begin
              r_state <= S_DBL;
            end else begin
              r_y     <= w_step[BITWIDTH-1:0];
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DBL: begin
          r_acc   <= w_dbl_red;
          r_y     <= w_dbl_red[BITWIDTH-1:0];
          r_err   <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !sys_rst;
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;
  assign err       = r_err;

endmodule
